// File: rtl/cmp_col_pkg.sv
// Shared types and constants for the column max-reduction block.
package cmp_col_pkg;
  localparam int CMP_WIDTH_DEF      = 16;
  localparam int LOCATION_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF      = 16;

  // Most negative score at the default width; wider builds derive their own.
  localparam logic signed [CMP_WIDTH_DEF-1:0] CMP_MIN = {1'b1, {(CMP_WIDTH_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/cmp_col_unit.sv
// Registered compare-select of running maximum vs incoming element.
// CMP_COL_TIE_FIRST_EN: equal scores keep the earlier location instead of the later one.
module cmp_col_unit
  import cmp_col_pkg::*;
#(
  parameter int CMP_WIDTH      = CMP_WIDTH_DEF,
  parameter int LOCATION_WIDTH = LOCATION_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             init_i,
  input  logic                             upd_i,
  input  logic signed [CMP_WIDTH-1:0]      value_i,
  input  logic        [LOCATION_WIDTH-1:0] loc_i,
  output logic signed [CMP_WIDTH-1:0]      acc_o,
  output logic        [LOCATION_WIDTH-1:0] loc_o
);
  localparam logic signed [CMP_WIDTH-1:0] ACC_MIN = {1'b1, {(CMP_WIDTH-1){1'b0}}};

  logic signed [CMP_WIDTH-1:0]      acc_q, acc_d;
  logic        [LOCATION_WIDTH-1:0] loc_q, loc_d;
  logic                             take;

  always_comb begin
`ifdef CMP_COL_TIE_FIRST_EN
    take = (value_i > acc_q);
`else
    take = (value_i >= acc_q);
`endif
    acc_d = acc_q;
    loc_d = loc_q;
    if (init_i) begin
      acc_d = ACC_MIN;
      loc_d = '0;
    end else if (upd_i && take) begin
      acc_d = value_i;
      loc_d = loc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= ACC_MIN;
      loc_q <= '0;
    end else begin
      acc_q <= acc_d;
      loc_q <= loc_d;
    end
  end

  assign acc_o = acc_q;
  assign loc_o = loc_q;
endmodule

// File: rtl/cmp_col_ctrl.sv
// Column max-reduction controller: FSM, element counter and both handshakes.
// Tie behaviour is selected in cmp_col_unit by CMP_COL_TIE_FIRST_EN.
module cmp_col_ctrl
  import cmp_col_pkg::*;
#(
  parameter int CMP_WIDTH      = CMP_WIDTH_DEF,
  parameter int LOCATION_WIDTH = LOCATION_WIDTH_DEF,
  parameter int LEN_WIDTH      = LEN_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             start,
  input  logic        [LEN_WIDTH-1:0]      col_len,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [CMP_WIDTH-1:0]      value_in,
  input  logic        [LOCATION_WIDTH-1:0] location_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [CMP_WIDTH-1:0]      max_out,
  output logic        [LOCATION_WIDTH-1:0] location_out,
  output logic                             empty_out,
  output logic                             busy
);
  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 empty_q, empty_d;
  logic                 take_start, accept, last;

  assign take_start = (state_q == S_IDLE) && start;
  assign accept     = in_valid && in_ready;
  assign last       = accept && (cnt_q == LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (col_len == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == S_RUN);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Counter and empty flag ride alongside the FSM; clear wins over everything.
  always_comb begin
    cnt_d   = cnt_q;
    empty_d = empty_q;
    if (clear) begin
      cnt_d   = '0;
      empty_d = 1'b0;
    end else if (take_start) begin
      cnt_d   = col_len;
      empty_d = (col_len == '0);
    end else begin
      if (accept) cnt_d = cnt_q - LEN_WIDTH'(1);
      if (out_valid && out_ready) empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

  assign empty_out = empty_q;

  cmp_col_unit #(
    .CMP_WIDTH      (CMP_WIDTH),
    .LOCATION_WIDTH (LOCATION_WIDTH)
  ) u_unit (
    .clk     (clk),
    .rst_n   (rst_n),
    .init_i  (clear || take_start),
    .upd_i   (accept && !clear),
    .value_i (value_in),
    .loc_i   (location_in),
    .acc_o   (max_out),
    .loc_o   (location_out)
  );
endmodule

// File: tb/tb_cmp_col_ctrl.sv
// Randomized + directed bench for cmp_col_ctrl against an argmax reference model.
module tb_cmp_col_ctrl;
  localparam int CW = 16, LW = 32, NW = 16;
  localparam logic signed [CW-1:0] MINV = 16'sh8000;

  logic clk = 1'b0;
  logic rst_n, clear, start, in_valid, out_ready;
  logic [NW-1:0] col_len;
  logic signed [CW-1:0] value_in;
  logic [LW-1:0] location_in;
  logic in_ready, out_valid, empty_out, busy;
  logic signed [CW-1:0] max_out;
  logic [LW-1:0] location_out;

  int total = 0, bad = 0;
  logic signed [CW-1:0] vals[16];
  logic [LW-1:0] locs[16];
  logic signed [CW-1:0] last_max;
  logic [LW-1:0] last_loc;

  cmp_col_ctrl #(.CMP_WIDTH(CW), .LOCATION_WIDTH(LW), .LEN_WIDTH(NW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .col_len(col_len),
    .in_valid(in_valid), .in_ready(in_ready), .value_in(value_in),
    .location_in(location_in), .out_valid(out_valid), .out_ready(out_ready),
    .max_out(max_out), .location_out(location_out), .empty_out(empty_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: the column maximum, then the latest (or earliest) element that holds it.
  // With first-wins ties an all-minimum column never displaces the initial location 0.
  task automatic model(input int len, output logic signed [CW-1:0] m, output logic [LW-1:0] l);
    bit found = 0;
    m = MINV;
    l = '0;
    for (int i = 0; i < len; i++) if (vals[i] > m) m = vals[i];
    for (int i = 0; i < len; i++) begin
      if (vals[i] == m) begin
`ifdef CMP_COL_TIE_FIRST_EN
        if (!found) l = locs[i];
`else
        l = locs[i];
`endif
        found = 1;
      end
    end
`ifdef CMP_COL_TIE_FIRST_EN
    if (m == MINV) l = '0;
`endif
  endtask

  task automatic fill(input int len);
    for (int i = 0; i < len; i++) begin
      case ($urandom_range(0, 5))
        0:       vals[i] = MINV;
        1:       vals[i] = 16'sh7fff;
        2, 3:    vals[i] = CW'(int'($urandom_range(0, 6)) - 3);
        default: vals[i] = CW'($urandom);
      endcase
      locs[i] = $urandom;
    end
  endtask

  task automatic run_col(input int len, input int gap_pct, input int hold);
    logic signed [CW-1:0] em;
    logic [LW-1:0] el;
    int k = 0, cyc = 0;
    model(len, em, el);
    start = 1; col_len = NW'(len); tick(); start = 0;
    while (k < len && cyc < 400) begin
      chk("in_ready_run", in_ready, 1);
      chk("ov_early", out_valid, 0);
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      value_in = vals[k]; location_in = locs[k];
      tick();
      if (in_valid) k++;
      cyc++;
    end
    in_valid = 0;
    if (k < len) chk("run_timeout", k, len);
    chk("ov_latency", out_valid, 1);
    chk("max", max_out, em);
    chk("loc", location_out, el);
    chk("empty", empty_out, len == 0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 0; start = $urandom; in_valid = $urandom; value_in = 16'sh7fff; location_in = $urandom;
      tick();
      chk("hold_ov", out_valid, 1);
      chk("hold_max", max_out, em);
      chk("hold_loc", location_out, el);
      chk("hold_empty", empty_out, len == 0);
      chk("hold_busy", busy, 1);
      chk("hold_rdy", in_ready, 0);
    end
    in_valid = 0; out_ready = 1; start = 1; col_len = 3;
    tick();
    out_ready = 0; start = 0;
    chk("post_ov", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_empty", empty_out, 0);
    last_max = em; last_loc = el;
  endtask

  initial begin
    rst_n = 0; clear = 0; start = 0; in_valid = 0; out_ready = 0;
    col_len = '0; value_in = '0; location_in = '0;
    tick(); tick();
    chk("rst_rdy", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty_out, 0);
    chk("rst_max", max_out, MINV);
    chk("rst_loc", location_out, 0);
    rst_n = 1; tick();

    vals[0] = 3; vals[1] = -7; vals[2] = 12; vals[3] = 5;
    for (int i = 0; i < 4; i++) locs[i] = LW'(10 + i);
    run_col(4, 0, 1);
    chk("d035_max", last_max, 12);
    chk("d035_loc", last_loc, 12);

    vals[0] = 9; vals[1] = 9; vals[2] = 2;
    locs[0] = 1; locs[1] = 2; locs[2] = 3;
    run_col(3, 0, 0);
`ifdef CMP_COL_TIE_FIRST_EN
    chk("d036_loc", last_loc, 1);
`else
    chk("d036_loc", last_loc, 2);
`endif

    run_col(0, 0, 2);
    chk("d037_max", last_max, MINV);
    chk("d037_loc", last_loc, 0);

    vals[0] = MINV; vals[1] = MINV; locs[0] = 32'h55; locs[1] = 32'h66;
    run_col(2, 30, 5);

    // Abort after two of five elements.
    fill(5);
    start = 1; col_len = 5; tick(); start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; value_in = 16'sh7000; location_in = locs[i]; tick();
    end
    clear = 1; in_valid = 1; tick(); clear = 0; in_valid = 0;
    chk("clr_rdy", in_ready, 0);
    chk("clr_busy", busy, 0);
    chk("clr_max", max_out, MINV);
    chk("clr_loc", location_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("clr_ov", out_valid, 0);
    end
    vals[0] = -5; locs[0] = 32'hABCD;
    run_col(1, 0, 0);
    chk("clr_rerun_loc", last_loc, 32'hABCD);

    // Reset mid-RUN discards the column.
    fill(4);
    start = 1; col_len = 4; tick(); start = 0;
    in_valid = 1; value_in = vals[0]; location_in = locs[0]; tick(); in_valid = 0;
    rst_n = 0; #1;
    chk("rstrun_busy", busy, 0);
    chk("rstrun_ov", out_valid, 0);
    tick(); rst_n = 1; tick();
    chk("rstrun_ov2", out_valid, 0);

    for (int t = 0; t < 40; t++) begin
      int len = $urandom_range(0, 12);
      fill(len);
      run_col(len, $urandom_range(0, 60), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
